// File: rtl/pipeline_hazard_controller.sv
// Stall/flush/bubble controller for a 5-stage in-order pipeline with memory-wait timeout.
// Optional stall performance counter enabled by defining HAZARD_PERF_CNT_EN.
module pipeline_hazard_controller #(
  parameter int REG_ADDR_W   = 4,
  parameter int MEM_TIMEOUT  = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_ropa,
  input  logic                  id_ropa_is_reg,
  input  logic [REG_ADDR_W-1:0] id_ropb,
  input  logic                  id_ropb_is_reg,
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_memrd,
  input  logic                  br_taken,
  input  logic                  mem_req,
  input  logic                  mem_ack,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  stall_ex,
  output logic                  bubble_ex,
  output logic                  flush_id,
  output logic                  mem_timeout,
  output logic [1:0]            state,
  output logic [15:0]           stall_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2,
    ERROR    = 2'd3
  } state_e;

  // Register 15 denotes an immediate/zero operand and never carries a dependency.
  localparam logic [REG_ADDR_W-1:0] NO_REG      = REG_ADDR_W'(15);
  localparam logic [7:0]            TIMEOUT_VAL = 8'(MEM_TIMEOUT);
  localparam logic [2:0]            FLUSH_INIT  = 3'(FLUSH_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] wait_q, wait_d;
  logic [2:0] flush_q, flush_d;

  logic mem_stall, ropa_dep, ropb_dep, load_use, timeout_hit;
  logic stall_if_c, stall_id_c, stall_ex_c, bubble_c, flush_c;

  always_comb begin
    mem_stall   = mem_req & ~mem_ack;
    ropa_dep    = id_ropa_is_reg && (id_ropa == ex_rd);
    ropb_dep    = id_ropb_is_reg && (id_ropb == ex_rd);
    load_use    = (state_q == RUN) && !mem_stall && id_valid && ex_valid &&
                  ex_memrd && (ex_rd != NO_REG) && (ropa_dep || ropb_dep);
    timeout_hit = mem_stall && (wait_q == TIMEOUT_VAL - 8'd1);
  end

  always_comb begin
    state_d    = state_q;
    flush_d    = flush_q;
    wait_d     = mem_stall ? wait_q + 8'd1 : 8'd0;
    stall_if_c = 1'b0;
    stall_id_c = 1'b0;
    stall_ex_c = 1'b0;
    bubble_c   = 1'b0;
    flush_c    = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_stall) begin
          stall_if_c = 1'b1;
          stall_id_c = 1'b1;
          stall_ex_c = 1'b1;
          state_d    = MEM_WAIT;
        end else if (load_use) begin
          stall_if_c = 1'b1;
          stall_id_c = 1'b1;
          bubble_c   = 1'b1;
        end else if (br_taken) begin
          flush_c = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            flush_d = FLUSH_INIT;
          end
        end
      end
      MEM_WAIT: begin
        if (mem_stall) begin
          stall_if_c = 1'b1;
          stall_id_c = 1'b1;
          stall_ex_c = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      FLUSH: begin
        flush_c = 1'b1;
        // A memory stall freezes the flush sequence rather than consuming it.
        if (mem_stall) begin
          stall_if_c = 1'b1;
          stall_id_c = 1'b1;
          stall_ex_c = 1'b1;
        end else begin
          flush_d = flush_q - 3'd1;
          if (flush_q == 3'd1) state_d = RUN;
        end
      end
      ERROR: begin
        stall_if_c = 1'b1;
        stall_id_c = 1'b1;
        stall_ex_c = 1'b1;
        wait_d     = wait_q;
      end
      default: state_d = RUN;
    endcase

    if (state_q != ERROR && timeout_hit) state_d = ERROR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      wait_q  <= 8'd0;
      flush_q <= 3'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      flush_q <= flush_d;
    end
  end

  assign stall_if    = ~rst & stall_if_c;
  assign stall_id    = ~rst & stall_id_c;
  assign stall_ex    = ~rst & stall_ex_c;
  assign bubble_ex   = ~rst & bubble_c;
  assign flush_id    = ~rst & flush_c;
  assign mem_timeout = ~rst & (state_q == ERROR);
  assign state       = rst ? 2'd0 : state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_id && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) stall_cnt_q <= 16'd0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = rst ? 16'd0 : stall_cnt_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Self-checking bench for pipeline_hazard_controller: per-cycle model compare plus
// hand-computed checkpoints for load-use, branch flush, memory stall, timeout and reset.
module tb_pipeline_hazard_controller;

  localparam int REG_ADDR_W   = 4;
  localparam int MEM_TIMEOUT  = 16;
  localparam int FLUSH_CYCLES = 2;

  typedef struct packed {
    logic       rst;
    logic       id_valid;
    logic [3:0] id_ropa;
    logic       id_ropa_is_reg;
    logic [3:0] id_ropb;
    logic       id_ropb_is_reg;
    logic       ex_valid;
    logic [3:0] ex_rd;
    logic       ex_memrd;
    logic       br_taken;
    logic       mem_req;
    logic       mem_ack;
  } stim_t;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [3:0]  id_ropa;
  logic        id_ropa_is_reg;
  logic [3:0]  id_ropb;
  logic        id_ropb_is_reg;
  logic        ex_valid;
  logic [3:0]  ex_rd;
  logic        ex_memrd;
  logic        br_taken;
  logic        mem_req;
  logic        mem_ack;
  logic        stall_if, stall_id, stall_ex, bubble_ex, flush_id, mem_timeout;
  logic [1:0]  state;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 0;

  // Abstract model: an error flag, flush cycles still owed, a memory-wait flag,
  // the running count of unacked wait cycles, and the stall counter.
  bit m_err     = 0;
  int m_flush   = 0;
  bit m_memwait = 0;
  int m_wait    = 0;
  int m_cnt     = 0;

  pipeline_hazard_controller #(
    .REG_ADDR_W  (REG_ADDR_W),
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .FLUSH_CYCLES(FLUSH_CYCLES)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_ropa       (id_ropa),
    .id_ropa_is_reg(id_ropa_is_reg),
    .id_ropb       (id_ropb),
    .id_ropb_is_reg(id_ropb_is_reg),
    .ex_valid      (ex_valid),
    .ex_rd         (ex_rd),
    .ex_memrd      (ex_memrd),
    .br_taken      (br_taken),
    .mem_req       (mem_req),
    .mem_ack       (mem_ack),
    .stall_if      (stall_if),
    .stall_id      (stall_id),
    .stall_ex      (stall_ex),
    .bubble_ex     (bubble_ex),
    .flush_id      (flush_id),
    .mem_timeout   (mem_timeout),
    .state         (state),
    .stall_cnt     (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_checks++;
    if (actual != expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic driveInputs(input stim_t s);
    rst            = s.rst;
    id_valid       = s.id_valid;
    id_ropa        = s.id_ropa;
    id_ropa_is_reg = s.id_ropa_is_reg;
    id_ropb        = s.id_ropb;
    id_ropb_is_reg = s.id_ropb_is_reg;
    ex_valid       = s.ex_valid;
    ex_rd          = s.ex_rd;
    ex_memrd       = s.ex_memrd;
    br_taken       = s.br_taken;
    mem_req        = s.mem_req;
    mem_ack        = s.mem_ack;
  endtask

  // Inputs change 1 time unit after the rising edge; literal checks follow 2 units later.
  task automatic applyStimulus(input stim_t s);
    @(posedge clk);
    #1;
    driveInputs(s);
    #2;
  endtask

  // Per-cycle compare against the model, then advance the model across the coming edge.
  always @(negedge clk) begin
    if (check_en) begin
      bit ms, ld, run, was_flush;
      int e_if, e_id, e_ex, e_bub, e_fl, e_to, e_st, nwait;
      e_if = 0; e_id = 0; e_ex = 0; e_bub = 0; e_fl = 0; e_to = 0; e_st = 0;
      ms        = mem_req && !mem_ack;
      was_flush = (m_flush > 0);
      run       = !m_err && !was_flush && !m_memwait;
      ld        = run && !ms && id_valid && ex_valid && ex_memrd && (ex_rd != 4'd15) &&
                  ((id_ropa_is_reg && id_ropa == ex_rd) || (id_ropb_is_reg && id_ropb == ex_rd));
      if (!rst) begin
        e_st = m_err ? 3 : was_flush ? 2 : m_memwait ? 1 : 0;
        if (m_err) begin
          e_if = 1; e_id = 1; e_ex = 1; e_to = 1;
        end else if (ms) begin
          e_if = 1; e_id = 1; e_ex = 1; e_fl = was_flush ? 1 : 0;
        end else if (was_flush) begin
          e_fl = 1;
        end else if (run) begin
          if (ld) begin
            e_if = 1; e_id = 1; e_bub = 1;
          end else if (br_taken) begin
            e_fl = 1;
          end
        end
      end
      checkOutput("stall_if", int'(stall_if), e_if);
      checkOutput("stall_id", int'(stall_id), e_id);
      checkOutput("stall_ex", int'(stall_ex), e_ex);
      checkOutput("bubble_ex", int'(bubble_ex), e_bub);
      checkOutput("flush_id", int'(flush_id), e_fl);
      checkOutput("mem_timeout", int'(mem_timeout), e_to);
      checkOutput("state", int'(state), e_st);
`ifdef HAZARD_PERF_CNT_EN
      checkOutput("stall_cnt", int'(stall_cnt), rst ? 0 : m_cnt);
`else
      checkOutput("stall_cnt", int'(stall_cnt), 0);
`endif
      if (rst) begin
        m_err = 0; m_flush = 0; m_memwait = 0; m_wait = 0; m_cnt = 0;
      end else begin
        if (e_id == 1 && m_cnt < 65535) m_cnt = m_cnt + 1;
        if (!m_err) begin
          nwait = ms ? m_wait + 1 : 0;
          if (nwait == MEM_TIMEOUT) begin
            m_err = 1;
          end else begin
            if (was_flush) begin
              if (!ms) m_flush = m_flush - 1;
            end else if (run && !ms && !ld && br_taken) begin
              m_flush = FLUSH_CYCLES - 1;
            end
            m_memwait = ms && !was_flush;
          end
          m_wait = nwait;
        end
      end
    end
  end

  initial begin
    stim_t s;
    s = '0;
    s.rst = 1'b1;
    driveInputs(s);
    check_en = 1;

    // Reset: everything low.
    applyStimulus(s);
    applyStimulus(s);
    checkOutput("reset_state", int'(state), 0);
    checkOutput("reset_stall_if", int'(stall_if), 0);

    s = '0;
    applyStimulus(s);
    checkOutput("idle_state", int'(state), 0);

    // Load-use on operand A.
    s = '0;
    s.id_valid = 1; s.ex_valid = 1; s.ex_memrd = 1; s.ex_rd = 4'd3;
    s.id_ropa = 4'd3; s.id_ropa_is_reg = 1;
    applyStimulus(s);
    checkOutput("lu_stall_if", int'(stall_if), 1);
    checkOutput("lu_stall_id", int'(stall_id), 1);
    checkOutput("lu_bubble", int'(bubble_ex), 1);
    checkOutput("lu_stall_ex", int'(stall_ex), 0);
    checkOutput("lu_state", int'(state), 0);

    // Register 15 never creates a dependency.
    s.ex_rd = 4'd15; s.id_ropa = 4'd15;
    applyStimulus(s);
    checkOutput("r15_stall_id", int'(stall_id), 0);
    checkOutput("r15_bubble", int'(bubble_ex), 0);

    // Operand B dependency, and operand A match that is not a register read.
    s.ex_rd = 4'd7; s.id_ropa = 4'd7; s.id_ropa_is_reg = 0;
    s.id_ropb = 4'd2; s.id_ropb_is_reg = 1;
    applyStimulus(s);
    checkOutput("imm_bubble", int'(bubble_ex), 0);
    s.id_ropb = 4'd7;
    applyStimulus(s);
    checkOutput("ropb_bubble", int'(bubble_ex), 1);

    // Load-use wins over a simultaneous taken branch.
    s.br_taken = 1;
    applyStimulus(s);
    checkOutput("lu_br_flush", int'(flush_id), 0);
    checkOutput("lu_br_bubble", int'(bubble_ex), 1);

    // Branch flush: two cycles of flush_id, state 0 -> 2 -> 0.
    s = '0; s.br_taken = 1;
    applyStimulus(s);
    checkOutput("br_flush0", int'(flush_id), 1);
    checkOutput("br_state0", int'(state), 0);
    s = '0;
    applyStimulus(s);
    checkOutput("br_flush1", int'(flush_id), 1);
    checkOutput("br_state1", int'(state), 2);
    applyStimulus(s);
    checkOutput("br_flush2", int'(flush_id), 0);
    checkOutput("br_state2", int'(state), 0);

    // Memory stall for 4 cycles, then ack.
    s = '0; s.mem_req = 1;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(s);
      checkOutput("ms_stall_ex", int'(stall_ex), 1);
      checkOutput("ms_state", int'(state), (i == 0) ? 0 : 1);
    end
    s.mem_ack = 1;
    applyStimulus(s);
    checkOutput("ack_stall_if", int'(stall_if), 0);
    checkOutput("ack_state", int'(state), 1);
    s = '0;
    applyStimulus(s);
    checkOutput("post_ack_state", int'(state), 0);

    // Memory stall during FLUSH holds the flush sequence.
    s = '0; s.br_taken = 1;
    applyStimulus(s);
    s = '0; s.mem_req = 1;
    applyStimulus(s);
    checkOutput("fl_ms_flush", int'(flush_id), 1);
    checkOutput("fl_ms_stall", int'(stall_ex), 1);
    checkOutput("fl_ms_state", int'(state), 2);
    applyStimulus(s);
    s = '0;
    applyStimulus(s);
    checkOutput("fl_resume_flush", int'(flush_id), 1);
    applyStimulus(s);
    checkOutput("fl_done_state", int'(state), 0);

    // Reset in the middle of a flush.
    s = '0; s.br_taken = 1;
    applyStimulus(s);
    s = '0; s.rst = 1;
    applyStimulus(s);
    checkOutput("rst_fl_flush", int'(flush_id), 0);
    s = '0;
    applyStimulus(s);
    checkOutput("rst_fl_state", int'(state), 0);
    checkOutput("rst_fl_flush2", int'(flush_id), 0);

    // Stall counter: 5 stall_id cycles after a fresh reset.
    s = '0; s.rst = 1;
    applyStimulus(s);
    s = '0; s.mem_req = 1;
    for (int i = 0; i < 5; i++) applyStimulus(s);
    s.mem_ack = 1;
    applyStimulus(s);
`ifdef HAZARD_PERF_CNT_EN
    checkOutput("perf_cnt", int'(stall_cnt), 5);
`else
    checkOutput("perf_cnt", int'(stall_cnt), 0);
`endif

    // Timeout: 16 unacked cycles land in ERROR, reset clears it.
    s = '0;
    applyStimulus(s);
    s.mem_req = 1;
    for (int i = 0; i < 16; i++) applyStimulus(s);
    checkOutput("pre_to_state", int'(state), 1);
    checkOutput("pre_to_flag", int'(mem_timeout), 0);
    applyStimulus(s);
    checkOutput("to_state", int'(state), 3);
    checkOutput("to_flag", int'(mem_timeout), 1);
    s.mem_ack = 1;
    applyStimulus(s);
    checkOutput("to_sticky", int'(state), 3);
    checkOutput("to_stall_id", int'(stall_id), 1);
    checkOutput("to_flush", int'(flush_id), 0);
    s = '0; s.rst = 1; s.mem_req = 1;
    applyStimulus(s);
    checkOutput("to_rst_state", int'(state), 0);
    checkOutput("to_rst_flag", int'(mem_timeout), 0);
    checkOutput("to_rst_stall", int'(stall_if), 0);
    s = '0;
    applyStimulus(s);
    checkOutput("to_after_state", int'(state), 0);
    checkOutput("to_after_flag", int'(mem_timeout), 0);

    applyStimulus(s);
    applyStimulus(s);
    @(posedge clk);
    check_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
